// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: opcodes, funct codes, ALU control
// values and the decoded control bundle.
package mips_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_write;
        logic      alu_src;
        logic      reg_dst;
        logic      branch;
        alu_ctrl_e alu_ctrl;
        logic      illegal;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports with write-through, one
// synchronous write port; register 0 is hardwired to zero.
module reg_file
    import mips_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [DATA_W-1:0]    rd1,
    output logic [DATA_W-1:0]    rd2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [DATA_W-1:0]    wd
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];
    logic              wr_en;

    assign wr_en = we && (wa != '0) && (int'(wa) < REG_COUNT);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // A read of the register being written this cycle sees the new value.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0 && int'(ra1) < REG_COUNT) begin
            rd1 = (wr_en && wa == ra1) ? wd : regs_q[ra1];
        end
        if (ra2 != '0 && int'(ra2) < REG_COUNT) begin
            rd2 = (wr_en && wa == ra2) ? wd : regs_q[ra2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID register, register file, control decoder,
// sign extension and early branch/jump resolution.
module decode_stage
    import mips_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int REG_COUNT     = 32
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [INSTR_WIDTH-1:0]   i_InstrF,
    input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4F,
    input  logic                     i_StallD,
    input  logic                     i_ForwardAD,
    input  logic                     i_ForwardBD,
    input  logic [31:0]              i_ALUOutM,
    input  logic                     i_RegWriteW,
    input  logic [REG_IDX_W-1:0]     i_WriteRegW,
    input  logic [31:0]              i_ResultW,
    output logic [ADDRESS_WIDTH-1:0] o_PCNextD,
    output logic                     o_PCSrcD,
    output logic                     o_LoadD,
    output logic [31:0]              o_RD1D,
    output logic [31:0]              o_RD2D,
    output logic [REG_IDX_W-1:0]     o_RsD,
    output logic [REG_IDX_W-1:0]     o_RtD,
    output logic [REG_IDX_W-1:0]     o_RdD,
    output logic [31:0]              o_SignImmD,
    output logic                     o_RegWriteD,
    output logic                     o_MemtoRegD,
    output logic                     o_MemWriteD,
    output logic                     o_ALUSrcD,
    output logic                     o_RegDstD,
    output logic                     o_BranchD,
    output logic [2:0]               o_ALUControlD,
    output logic                     o_ValidD,
    output logic                     o_IllegalD
);

    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic                     valid_q, valid_d;

    logic                     pcsrc;
    ctrl_t                    ctrl;
    logic                     is_illegal;
    logic [5:0]               funct;
    opcode_e                  opcode;
    logic [31:0]              rd1, rd2, cmp_a, cmp_b;
    logic                     eq, is_beq, is_bne, is_j;
    logic [31:0]              sign_imm;
    logic [ADDRESS_WIDTH-1:0] branch_tgt, jump_tgt;

    // IF/ID register: stall holds, a redirect flushes, otherwise load.
    always_comb begin
        instr_d   = i_InstrF;
        pcplus4_d = i_PCPlus4F;
        valid_d   = 1'b1;
        if (i_StallD) begin
            instr_d   = instr_q;
            pcplus4_d = pcplus4_q;
            valid_d   = valid_q;
        end else if (pcsrc) begin
            instr_d = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            instr_q   <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign opcode = opcode_e'(instr_q[31:26]);
    assign funct  = instr_q[5:0];

    always_comb begin
        ctrl       = '0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (instr_q != NOP_INSTR) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    case (funct)
                        FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
                        FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
                        FN_AND:  ctrl.alu_ctrl = ALU_AND;
                        FN_OR:   ctrl.alu_ctrl = ALU_OR;
                        FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
                        default: is_illegal    = 1'b1;
                    endcase
                end
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
            end
            OP_J: ;
            default: is_illegal = 1'b1;
        endcase
        // Bubbles and unsupported encodings must not reach execute with side effects.
        if (!valid_q || is_illegal) begin
            ctrl = '0;
        end
        ctrl.illegal = valid_q & is_illegal;
    end

    reg_file #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (32)
    ) u_reg_file (
        .clk (i_CLK),
        .rst (i_RST),
        .ra1 (instr_q[25:21]),
        .ra2 (instr_q[20:16]),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (i_RegWriteW),
        .wa  (i_WriteRegW),
        .wd  (i_ResultW)
    );

    assign sign_imm   = {{16{instr_q[15]}}, instr_q[15:0]};
    assign branch_tgt = pcplus4_q + ADDRESS_WIDTH'({sign_imm[29:0], 2'b00});
    assign jump_tgt   = {pcplus4_q[ADDRESS_WIDTH-1:28], instr_q[25:0], 2'b00};

    assign cmp_a  = i_ForwardAD ? i_ALUOutM : rd1;
    assign cmp_b  = i_ForwardBD ? i_ALUOutM : rd2;
    assign eq     = (cmp_a == cmp_b);
    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_j   = (opcode == OP_J);

    // Gating with the stall keeps a compare on stale operands from redirecting fetch.
    assign pcsrc = valid_q & ~i_StallD & ((is_beq & eq) | (is_bne & ~eq) | is_j);

    assign o_PCSrcD      = pcsrc;
    assign o_PCNextD     = is_j ? jump_tgt : branch_tgt;
    assign o_LoadD       = ~i_RST;
    assign o_RD1D        = rd1;
    assign o_RD2D        = rd2;
    assign o_RsD         = instr_q[25:21];
    assign o_RtD         = instr_q[20:16];
    assign o_RdD         = instr_q[15:11];
    assign o_SignImmD    = sign_imm;
    assign o_RegWriteD   = ctrl.reg_write;
    assign o_MemtoRegD   = ctrl.mem_to_reg;
    assign o_MemWriteD   = ctrl.mem_write;
    assign o_ALUSrcD     = ctrl.alu_src;
    assign o_RegDstD     = ctrl.reg_dst;
    assign o_BranchD     = ctrl.branch;
    assign o_ALUControlD = ctrl.alu_ctrl;
    assign o_ValidD      = valid_q;
    assign o_IllegalD    = ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random stimulus,
// all outputs compared against a behavioural model of the stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_f, pc4_f, alu_m, res_w;
    logic        stall, fwd_a, fwd_b, rw_w;
    logic [4:0]  wr_w;

    logic [31:0] pc_next, rd1, rd2, sign_imm;
    logic        pc_src, load, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch;
    logic        valid, illegal;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  alu_ctl;

    always #5 clk = ~clk;

    decode_stage dut (
        .i_CLK(clk), .i_RST(rst), .i_InstrF(instr_f), .i_PCPlus4F(pc4_f),
        .i_StallD(stall), .i_ForwardAD(fwd_a), .i_ForwardBD(fwd_b), .i_ALUOutM(alu_m),
        .i_RegWriteW(rw_w), .i_WriteRegW(wr_w), .i_ResultW(res_w),
        .o_PCNextD(pc_next), .o_PCSrcD(pc_src), .o_LoadD(load),
        .o_RD1D(rd1), .o_RD2D(rd2), .o_RsD(rs), .o_RtD(rt), .o_RdD(rd),
        .o_SignImmD(sign_imm), .o_RegWriteD(reg_write), .o_MemtoRegD(mem_to_reg),
        .o_MemWriteD(mem_write), .o_ALUSrcD(alu_src), .o_RegDstD(reg_dst),
        .o_BranchD(branch), .o_ALUControlD(alu_ctl), .o_ValidD(valid), .o_IllegalD(illegal)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Behavioural model state
    logic [31:0] m_rf [32];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid, m_pc4_known;

    function automatic logic [31:0] r_ins(input int s, input int t, input int d, input logic [5:0] fn);
        logic [4:0] s5, t5, d5;
        s5 = 5'(s); t5 = 5'(t); d5 = 5'(d);
        return {6'h00, s5, t5, d5, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
        logic [4:0] s5, t5;
        s5 = 5'(s); t5 = 5'(t);
        return {op, s5, t5, imm};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rw_w && wr_w == a) return res_w;
        return m_rf[a];
    endfunction

    // Packs {illegal, regwrite, memtoreg, memwrite, alusrc, regdst, branch, alu}
    function automatic logic [9:0] mk(input logic ill, input logic rwr, input logic m2r, input logic mw,
                                      input logic as, input logic rdst, input logic br, input logic [2:0] alu);
        return {ill, rwr, m2r, mw, as, rdst, br, alu};
    endfunction

    function automatic logic [9:0] m_ctrl(input logic [31:0] ins, input logic v);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (!v) return 10'd0;
        case (op)
            6'h00: begin
                if (ins == 32'd0) return 10'd0;
                case (fn)
                    6'h20: return mk(0, 1, 0, 0, 0, 1, 0, 3'b010);
                    6'h22: return mk(0, 1, 0, 0, 0, 1, 0, 3'b110);
                    6'h24: return mk(0, 1, 0, 0, 0, 1, 0, 3'b000);
                    6'h25: return mk(0, 1, 0, 0, 0, 1, 0, 3'b001);
                    6'h2A: return mk(0, 1, 0, 0, 0, 1, 0, 3'b111);
                    default: return mk(1, 0, 0, 0, 0, 0, 0, 3'b000);
                endcase
            end
            6'h23: return mk(0, 1, 1, 0, 1, 0, 0, 3'b010);
            6'h2B: return mk(0, 0, 0, 1, 1, 0, 0, 3'b010);
            6'h08: return mk(0, 1, 0, 0, 1, 0, 0, 3'b010);
            6'h04, 6'h05: return mk(0, 0, 0, 0, 0, 0, 1, 3'b110);
            6'h02: return 10'd0;
            default: return mk(1, 0, 0, 0, 0, 0, 0, 3'b000);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_pc4_known = 1'b1;
    endtask

    // Compare every output against the model mid-cycle, then clock once.
    task automatic tick();
        logic [31:0] a, b, imm, bt, jt;
        logic [5:0]  op;
        logic        eq, taken;
        op    = m_instr[31:26];
        a     = fwd_a ? alu_m : m_read(m_instr[25:21]);
        b     = fwd_b ? alu_m : m_read(m_instr[20:16]);
        eq    = (a == b);
        taken = m_valid && !stall && ((op == 6'h04 && eq) || (op == 6'h05 && !eq) || op == 6'h02);
        imm   = {{16{m_instr[15]}}, m_instr[15:0]};
        bt    = m_pc4 + imm * 4;
        jt    = {m_pc4[31:28], m_instr[25:0], 2'b00};

        chk("pcsrc", pc_src, taken);
        if (m_pc4_known) chk("pcnext", pc_next, (op == 6'h02) ? jt : bt);
        chk("load", load, !rst);
        chk("rd1", rd1, m_read(m_instr[25:21]));
        chk("rd2", rd2, m_read(m_instr[20:16]));
        chk("regs", {rs, rt, rd}, {m_instr[25:21], m_instr[20:16], m_instr[15:11]});
        chk("signimm", sign_imm, imm);
        chk("ctrl", {illegal, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, alu_ctl},
            m_ctrl(m_instr, m_valid));
        chk("valid", valid, m_valid);

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (rw_w && wr_w != 5'd0) m_rf[wr_w] = res_w;
            if (!stall) begin
                if (taken) begin
                    m_instr = 32'd0; m_valid = 1'b0; m_pc4_known = 1'b0;
                end else begin
                    m_instr = instr_f; m_pc4 = pc4_f; m_valid = 1'b1; m_pc4_known = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        instr_f = 32'd0; pc4_f = 32'd0; stall = 0; fwd_a = 0; fwd_b = 0;
        alu_m = 32'd0; rw_w = 0; wr_w = 5'd0; res_w = 32'd0;
    endtask

    task automatic wr_reg(input int r, input logic [31:0] v);
        instr_f = 32'd0; rw_w = 1; wr_w = 5'(r); res_w = v;
        #4; tick();
        rw_w = 0;
    endtask

    logic [31:0] j_ins, beq_ins, bne_ins;

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        model_reset();

        // Reset held
        #4;
        chk("rst_pcsrc", pc_src, 0);
        chk("rst_load", load, 0);
        chk("rst_pcnext", pc_next, 0);
        chk("rst_valid", valid, 0);
        tick();
        rst = 0;
        #4;
        chk("idle_load", load, 1);
        chk("idle_valid", valid, 0);
        tick();

        // W-stage write-through and r0 immunity
        instr_f = r_ins(5, 0, 3, 6'h20);
        #4; tick();
        rw_w = 1; wr_w = 5'd5; res_w = 32'h1234;
        #4;
        chk("bypass_rd1", rd1, 32'h1234);
        tick();
        wr_w = 5'd0; res_w = 32'hFFFF;
        #4;
        chk("r0_rd2", rd2, 32'd0);
        tick();
        rw_w = 0;
        #4;
        chk("r5_kept", rd1, 32'h1234);
        chk("r0_after", rd2, 32'd0);
        tick();

        // beq taken then flush, then not taken
        wr_reg(1, 7);
        wr_reg(2, 7);
        beq_ins = i_ins(6'h04, 1, 2, 16'd3);
        instr_f = beq_ins; pc4_f = 32'h104;
        #4; tick();
        instr_f = r_ins(1, 2, 4, 6'h20); pc4_f = 32'h108;
        #4;
        chk("beq_pcsrc", pc_src, 1);
        chk("beq_target", pc_next, 32'h110);
        tick();
        #4;
        chk("flush_valid", valid, 0);
        tick();
        wr_reg(2, 8);
        instr_f = beq_ins; pc4_f = 32'h104;
        #4; tick();
        instr_f = 32'd0;
        #4;
        chk("beq_nt_pcsrc", pc_src, 0);
        tick();

        // bne with forwarding under a two-cycle stall
        wr_reg(2, 9);
        bne_ins = i_ins(6'h05, 1, 2, 16'hFFFF);
        instr_f = bne_ins; pc4_f = 32'h200;
        #4; tick();
        stall = 1; fwd_a = 1; alu_m = 32'd9; instr_f = r_ins(3, 3, 3, 6'h25);
        #4;
        chk("stall1_pcsrc", pc_src, 0);
        tick();
        #4;
        chk("stall2_pcsrc", pc_src, 0);
        chk("stall_hold_br", branch, 1);
        chk("stall_hold_rt", rt, 2);
        tick();
        stall = 0;
        #4;
        chk("unstall_pcsrc", pc_src, 0);
        tick();
        fwd_a = 0;

        // Jump
        j_ins = {6'h02, 26'h40};
        instr_f = j_ins; pc4_f = 32'hA000_0004;
        #4; tick();
        instr_f = 32'd0;
        #4;
        chk("j_target", pc_next, 32'hA000_0100);
        chk("j_pcsrc", pc_src, 1);
        tick();

        // Unsupported opcode
        instr_f = {6'h3F, 26'h0};
        #4; tick();
        #4;
        chk("ill_flag", illegal, 1);
        chk("ill_regwrite", reg_write, 0);
        tick();

        // Reset coinciding with a taken jump
        instr_f = j_ins; pc4_f = 32'hA000_0004;
        #4; tick();
        rst = 1;
        #4; tick();
        rst = 0; instr_f = 32'd0;
        #4;
        chk("rstbr_pcsrc", pc_src, 0);
        chk("rstbr_valid", valid, 0);
        tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r, imm32;
            logic [5:0]  ops [7];
            logic [5:0]  fns [6];
            ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02};
            fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
            r = $urandom_range(0, 9);
            imm32 = $urandom;
            if (r < 7) begin
                if (ops[r] == 6'h00)
                    instr_f = r_ins($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
                                    fns[$urandom_range(0, 5)]);
                else
                    instr_f = i_ins(ops[r], $urandom_range(0, 3), $urandom_range(0, 3), imm32[15:0]);
            end else if (r == 7) begin
                instr_f = 32'd0;
            end else begin
                instr_f = {6'h3F - 6'($urandom_range(0, 3)), imm32[25:0]};
            end
            imm32 = $urandom;
            pc4_f = {imm32[31:2], 2'b00};
            stall = ($urandom_range(0, 4) == 0);
            fwd_a = $urandom_range(0, 1) == 1;
            fwd_b = $urandom_range(0, 1) == 1;
            alu_m = $urandom_range(0, 3);
            rw_w  = $urandom_range(0, 1) == 1;
            wr_w  = 5'($urandom_range(0, 3));
            res_w = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 3);
            rst   = ($urandom_range(0, 59) == 0);
            #4; tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
